multi_cycle_seq: RTL and testbench

MULTI_CYCLE_SEQ -- requirements
Module: multi_cycle_seq

---
 rtl/multi_cycle_seq.sv | 188 ++++++++++++++++++
 tb/tb_multi_cycle_seq.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_cycle_seq.sv
// Multi-cycle CPU control sequencer: IF/ID/EXE/MEM/WB with memory wait timeout,
// external stall, terminal HALT/ERR states and a retired-instruction counter.
module multi_cycle_seq #(
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic [2:0]       opClass,
    input  logic             zero,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    input  logic             stall_req,
    output logic [2:0]       state,
    output logic             PCWre,
    output logic             IRWre,
    output logic             RegWre,
    output logic [1:0]       pc_sel,
    output logic             imem_req,
    output logic             dmem_rd,
    output logic             dmem_wr,
    output logic             halted,
    output logic             timeout_err,
    output logic [CNT_W-1:0] retired
);

    localparam int unsigned WAIT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

    localparam logic [2:0] OP_LOAD   = 3'd2;
    localparam logic [2:0] OP_STORE  = 3'd3;
    localparam logic [2:0] OP_BRANCH = 3'd4;
    localparam logic [2:0] OP_JUMP   = 3'd5;
    localparam logic [2:0] OP_JAL    = 3'd6;
    localparam logic [2:0] OP_HALT   = 3'd7;

    typedef enum logic [2:0] {
        StIf   = 3'b000,
        StId   = 3'b001,
        StExe  = 3'b010,
        StMem  = 3'b011,
        StWb   = 3'b100,
        StHalt = 3'b101,
        StErr  = 3'b110,
        StBad  = 3'b111
    } state_e;

    state_e            r_state;
    state_e            w_state_nxt;
    logic [WAIT_W-1:0] r_wait;
    logic [WAIT_W-1:0] w_wait_nxt;
    logic [CNT_W-1:0]  r_retired;

    logic       w_pcwre;
    logic       w_irwre;
    logic       w_regwre;
    logic [1:0] w_pc_sel;
    logic       w_imem_req;
    logic       w_dmem_rd;
    logic       w_dmem_wr;
    logic       w_halted;
    logic       w_timeout;
    logic       w_waiting;

    always_comb begin
        w_state_nxt = r_state;
        w_pcwre     = 1'b0;
        w_irwre     = 1'b0;
        w_regwre    = 1'b0;
        w_pc_sel    = 2'b00;
        w_imem_req  = 1'b0;
        w_dmem_rd   = 1'b0;
        w_dmem_wr   = 1'b0;
        w_halted    = 1'b0;
        w_timeout   = 1'b0;
        w_waiting   = 1'b0;

        unique case (r_state)
            StIf: begin
                w_imem_req = 1'b1;
                if (imem_ready) begin
                    w_irwre     = 1'b1;
                    w_state_nxt = StId;
                end else if (r_wait == WAIT_MAX) begin
                    w_state_nxt = StErr;
                end else begin
                    w_waiting = 1'b1;
                end
            end
            StId: begin
                case (opClass)
                    OP_HALT: w_state_nxt = StHalt;
                    OP_JUMP: begin
                        w_state_nxt = StIf;
                        w_pcwre     = 1'b1;
                        w_pc_sel    = 2'b10;
                    end
                    OP_JAL:  w_state_nxt = StWb;
                    default: w_state_nxt = StExe;
                endcase
            end
            StExe: begin
                case (opClass)
                    OP_LOAD, OP_STORE: w_state_nxt = StMem;
                    OP_BRANCH: begin
                        w_state_nxt = StIf;
                        w_pcwre     = 1'b1;
                        w_pc_sel    = zero ? 2'b01 : 2'b00;
                    end
                    default: w_state_nxt = StWb;
                endcase
            end
            StMem: begin
                w_dmem_rd = (opClass == OP_LOAD);
                w_dmem_wr = (opClass == OP_STORE);
                if (dmem_ready) begin
                    if (opClass == OP_LOAD) begin
                        w_state_nxt = StWb;
                    end else begin
                        w_state_nxt = StIf;
                        w_pcwre     = 1'b1;
                    end
                end else if (r_wait == WAIT_MAX) begin
                    w_state_nxt = StErr;
                end else begin
                    w_waiting = 1'b1;
                end
            end
            StWb: begin
                w_regwre    = 1'b1;
                w_pcwre     = 1'b1;
                w_pc_sel    = (opClass == OP_JAL) ? 2'b10 : 2'b00;
                w_state_nxt = StIf;
            end
            StHalt: w_halted  = 1'b1;
            StErr:  w_timeout = 1'b1;
            StBad:  w_state_nxt = StErr;
        endcase

        // Freeze: request strobes keep their state-defined value, write strobes drop.
        if (stall_req && (r_state <= StWb)) begin
            w_state_nxt = r_state;
            w_pcwre     = 1'b0;
            w_irwre     = 1'b0;
            w_regwre    = 1'b0;
            w_pc_sel    = 2'b00;
            w_waiting   = 1'b0;
        end

        if (w_state_nxt != r_state) begin
            w_wait_nxt = '0;
        end else if (w_waiting) begin
            w_wait_nxt = r_wait + 1'b1;
        end else begin
            w_wait_nxt = r_wait;
        end
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            r_state   <= StIf;
            r_wait    <= '0;
            r_retired <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_wait  <= w_wait_nxt;
            if (w_pcwre) begin
                r_retired <= r_retired + 1'b1;
            end
        end
    end

    // Reset overrides the combinational outputs without waiting for a clock.
    always_comb begin
        state       = r_state;
        retired     = r_retired;
        PCWre       = Reset & w_pcwre;
        IRWre       = Reset & w_irwre;
        RegWre      = Reset & w_regwre;
        pc_sel      = Reset ? w_pc_sel : 2'b00;
        imem_req    = Reset & w_imem_req;
        dmem_rd     = Reset & w_dmem_rd;
        dmem_wr     = Reset & w_dmem_wr;
        halted      = Reset & w_halted;
        timeout_err = Reset & w_timeout;
    end

endmodule

// File: tb/tb_multi_cycle_seq.sv
// Scoreboard bench for multi_cycle_seq: expected retirements are queued by the
// stimulus and checked by a negedge monitor whenever PCWre is presented.
module tb_multi_cycle_seq;

    logic        CLK = 1'b0;
    logic        Reset;
    logic [2:0]  opClass;
    logic        zero;
    logic        imem_ready;
    logic        dmem_ready;
    logic        stall_req;
    logic [2:0]  state;
    logic        PCWre, IRWre, RegWre;
    logic [1:0]  pc_sel;
    logic        imem_req, dmem_rd, dmem_wr, halted, timeout_err;
    logic [15:0] retired;

    logic [2:0]  state_4;
    logic        PCWre_4, IRWre_4, RegWre_4;
    logic [1:0]  pc_sel_4;
    logic        imem_req_4, dmem_rd_4, dmem_wr_4, halted_4, timeout_err_4;
    logic [3:0]  retired_4;

    logic [9:0]  outs;
    assign outs = {PCWre, IRWre, RegWre, imem_req, dmem_rd, dmem_wr, halted, timeout_err, pc_sel};

    multi_cycle_seq dut (
        .CLK(CLK), .Reset(Reset), .opClass(opClass), .zero(zero), .imem_ready(imem_ready),
        .dmem_ready(dmem_ready), .stall_req(stall_req), .state(state), .PCWre(PCWre),
        .IRWre(IRWre), .RegWre(RegWre), .pc_sel(pc_sel), .imem_req(imem_req),
        .dmem_rd(dmem_rd), .dmem_wr(dmem_wr), .halted(halted), .timeout_err(timeout_err),
        .retired(retired)
    );

    multi_cycle_seq #(.CNT_W(4)) dut4 (
        .CLK(CLK), .Reset(Reset), .opClass(opClass), .zero(zero), .imem_ready(imem_ready),
        .dmem_ready(dmem_ready), .stall_req(stall_req), .state(state_4), .PCWre(PCWre_4),
        .IRWre(IRWre_4), .RegWre(RegWre_4), .pc_sel(pc_sel_4), .imem_req(imem_req_4),
        .dmem_rd(dmem_rd_4), .dmem_wr(dmem_wr_4), .halted(halted_4),
        .timeout_err(timeout_err_4), .retired(retired_4)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int         lat;
        logic [1:0] sel;
        logic       rw;
        logic [2:0] st;
        int         nrd;
        int         nwr;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Monitor: latency and memory-strobe counts are measured per retired instruction.
    initial begin
        exp_t e;
        int   cyc;
        int   nrd;
        int   nwr;
        cyc = 0; nrd = 0; nwr = 0;
        forever begin
            @(negedge CLK);
            if (!Reset) begin
                cyc = 0; nrd = 0; nwr = 0;
            end else begin
                cyc++;
                if (dmem_rd) nrd++;
                if (dmem_wr) nwr++;
                if (PCWre) begin
                    n_tests++;
                    if (sb.size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_retire: got PCWre=1 in state %0d, required no retire",
                                 state);
                    end else begin
                        e = sb.pop_front();
                        if (cyc != e.lat || pc_sel != e.sel || RegWre != e.rw || state != e.st ||
                            nrd != e.nrd || nwr != e.nwr) begin
                            n_fail++;
                            $display("FAIL retire: got lat=%0d sel=%b rw=%b st=%0d rd=%0d wr=%0d, required lat=%0d sel=%b rw=%b st=%0d rd=%0d wr=%0d",
                                     cyc, pc_sel, RegWre, state, nrd, nwr,
                                     e.lat, e.sel, e.rw, e.st, e.nrd, e.nwr);
                        end
                    end
                    cyc = 0; nrd = 0; nwr = 0;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic expect_instr(input int lat, input logic [1:0] sel, input logic rw,
                                input logic [2:0] st, input int rd, input int wr);
        exp_t e;
        e.lat = lat; e.sel = sel; e.rw = rw; e.st = st; e.nrd = rd; e.nwr = wr;
        sb.push_back(e);
    endtask

    task automatic wait_retire(input string name);
        bit found = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge CLK);
            if (PCWre === 1'b1) begin
                found = 1;
                break;
            end
        end
        if (!found) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: got no PCWre within 60 cycles, required a retire", name);
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_state(input logic [2:0] st, input string name);
        bit found = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge CLK);
            if (state === st) begin
                found = 1;
                break;
            end
        end
        if (!found) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: got state %0d after 60 cycles, required %0d", name, state, st);
        end
    endtask

    task automatic run(input logic [2:0] op, input logic z, input int lat, input logic [1:0] sel,
                       input logic rw, input logic [2:0] st, input int rd, input int wr,
                       input string name);
        opClass = op;
        zero    = z;
        expect_instr(lat, sel, rw, st, rd, wr);
        wait_retire(name);
    endtask

    task automatic do_reset();
        #2 Reset = 1'b0;
        @(posedge CLK);
        #1 Reset = 1'b1;
    endtask

    initial begin
        int n_if;
        Reset      = 1'b0;
        opClass    = 3'd0;
        zero       = 1'b0;
        imem_ready = 1'b1;
        dmem_ready = 1'b1;
        stall_req  = 1'b0;
        #3;
        check("reset_outs", {22'd0, outs}, 32'd0);
        check("reset_state_retired", {13'd0, state, retired}, 32'd0);
        @(posedge CLK);
        #1 Reset = 1'b1;

        // Zero-wait program: R, load, store, taken branch, jump, jal.
        run(3'd0, 1'b0, 4, 2'b00, 1'b1, 3'd4, 0, 0, "r_alu");
        run(3'd2, 1'b0, 5, 2'b00, 1'b1, 3'd4, 1, 0, "load");
        run(3'd3, 1'b0, 4, 2'b00, 1'b0, 3'd3, 0, 1, "store");
        run(3'd4, 1'b1, 3, 2'b01, 1'b0, 3'd2, 0, 0, "branch_taken");
        run(3'd5, 1'b0, 2, 2'b10, 1'b0, 3'd1, 0, 0, "jump");
        run(3'd6, 1'b0, 3, 2'b10, 1'b1, 3'd4, 0, 0, "jal");
        check("retired_after_6", {16'd0, retired}, 32'd6);
        run(3'd1, 1'b0, 4, 2'b00, 1'b1, 3'd4, 0, 0, "i_alu");
        run(3'd4, 1'b0, 3, 2'b00, 1'b0, 3'd2, 0, 0, "branch_not_taken");

        // Load whose data memory answers on the fourth MEM cycle.
        opClass = 3'd2;
        dmem_ready = 1'b0;
        expect_instr(8, 2'b00, 1'b1, 3'd4, 4, 0);
        wait_state(3'd2, "load_wait_exe");
        @(posedge CLK);
        #1;
        repeat (3) begin
            @(posedge CLK);
            #1;
        end
        dmem_ready = 1'b1;
        wait_retire("load_wait");

        // Five stalled edges in EXE.
        opClass = 3'd0;
        expect_instr(9, 2'b00, 1'b1, 3'd4, 0, 0);
        wait_state(3'd1, "stall_exe_id");
        @(posedge CLK);
        #1 stall_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            check("exe_stall", {28'd0, state, PCWre | IRWre | RegWre}, {28'd0, 3'd2, 1'b0});
        end
        @(posedge CLK);
        #1 stall_req = 1'b0;
        wait_retire("exe_stall_resume");

        // Two stalled IF cycles with the instruction already available.
        opClass = 3'd5;
        expect_instr(4, 2'b10, 1'b0, 3'd1, 0, 0);
        stall_req = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge CLK);
            check("if_stall", {26'd0, state, imem_req, IRWre, PCWre}, {26'd0, 3'd0, 3'b100});
        end
        @(posedge CLK);
        #1 stall_req = 1'b0;
        wait_retire("if_stall_resume");
        check("retired_after_11", {16'd0, retired}, 32'd11);

        // Counter wrap on the 4-bit instance.
        do_reset();
        for (int i = 0; i < 17; i++) run(3'd5, 1'b0, 2, 2'b10, 1'b0, 3'd1, 0, 0, "jump_wrap");
        check("retired_17", {16'd0, retired}, 32'd17);
        check("retired_4_wrap", {28'd0, retired_4}, 32'd1);

        // Asynchronous reset while a store is waiting in MEM.
        do_reset();
        run(3'd5, 1'b0, 2, 2'b10, 1'b0, 3'd1, 0, 0, "jump_pre_reset");
        opClass = 3'd3;
        dmem_ready = 1'b0;
        wait_state(3'd3, "store_mem");
        check("store_mem_wr", {31'd0, dmem_wr}, 32'd1);
        #2 Reset = 1'b0;
        #1;
        check("async_reset_outs", {22'd0, outs}, 32'd0);
        check("async_reset_state", {13'd0, state, retired}, 32'd0);
        check("async_reset_retired4", {28'd0, retired_4}, 32'd0);
        @(posedge CLK);
        #1 Reset = 1'b1;
        opClass = 3'd7;
        dmem_ready = 1'b1;
        @(negedge CLK);
        check("first_if", {28'd0, state, imem_req}, {28'd0, 3'd0, 1'b1});

        // Halt is terminal and quiet.
        wait_state(3'd5, "halt_entry");
        check("halt_outs", {22'd0, outs}, 32'd8);
        repeat (3) @(negedge CLK);
        check("halt_hold", {19'd0, state, outs}, {19'd0, 3'd5, 10'd8});

        // Instruction fetch never answers: ERR after MAX_WAIT+1 IF cycles.
        imem_ready = 1'b0;
        do_reset();
        n_if = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            if (state == 3'd6) break;
            if (state == 3'd0) n_if++;
        end
        check("timeout_if_cycles", n_if, 32'd16);
        check("err_outs", {19'd0, state, outs}, {19'd0, 3'd6, 10'd4});
        repeat (3) @(negedge CLK);
        check("err_hold", {29'd0, state}, 32'd6);

        // Ready on the last allowed wait cycle wins over the timeout.
        do_reset();
        repeat (15) @(negedge CLK);
        @(posedge CLK);
        #1 imem_ready = 1'b1;
        @(negedge CLK);
        check("late_ready_irwre", {28'd0, state, IRWre}, {28'd0, 3'd0, 1'b1});
        @(negedge CLK);
        check("late_ready_id", {29'd0, state}, 32'd1);

        check("scoreboard_drain", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
